pc_fetch_control: RTL and testbench

Program-counter and instruction-fetch sequencer for the RV32I core. It sits directly downstream of the jump/branch decision logic: it consumes the taken-jump flag and target from the execute stage, redirects the PC, and squashes any wrong-path fetch. It drives a single-outstanding-request instruction-memory port and holds the fetched instruction in a one-entry output buffer for decode.

---
 rtl/pc_fetch_control.sv | 97 +++++++++
 tb/tb_pc_fetch_control.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_control.sv
// rtl/pc_fetch_control.sv - PC register and single-outstanding instruction fetch sequencer
module pc_fetch_control #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_Clk_1,
    input  logic        i_Rst_n_1,
    input  logic        i_Jump_1,
    input  logic [31:0] i_JumpTarget_32,
    input  logic        i_Stall_1,
    input  logic        i_ImemReady_1,
    input  logic        i_ImemValid_1,
    input  logic [31:0] i_ImemData_32,
    output logic        o_ImemReq_1,
    output logic [31:0] o_ImemAddr_32,
    output logic        o_InstValid_1,
    output logic [31:0] o_Inst_32,
    output logic [31:0] o_InstPC_32,
    output logic        o_Flush_1
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        free;
    logic        accepted;
    logic        fill;

    // Only issue when the buffer is empty or draining, so the lone response always has a home.
    assign free          = ~o_InstValid_1 | ~i_Stall_1;
    assign o_ImemReq_1   = (state == FETCH) & free;
    assign o_ImemAddr_32 = pc;
    assign accepted      = o_ImemReq_1 & i_ImemReady_1;
    assign fill          = (state == WAIT) & i_ImemValid_1;

    // Sequencer: a taken jump overrides every fill, consume and advance decision.
    always_ff @(posedge i_Clk_1) begin
        if (!i_Rst_n_1) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            req_pc        <= RESET_PC;
            o_InstValid_1 <= 1'b0;
            o_Inst_32     <= NOP;
            o_InstPC_32   <= RESET_PC;
            o_Flush_1     <= 1'b0;
        end else begin
            o_Flush_1 <= i_Jump_1;
            if (i_Jump_1) begin
                pc            <= {i_JumpTarget_32[31:2], 2'b00};
                o_InstValid_1 <= 1'b0;
                case (state)
                    IDLE:    state <= FETCH;
                    FETCH:   state <= accepted ? DROP : FETCH;
                    WAIT:    state <= i_ImemValid_1 ? FETCH : DROP;
                    default: state <= i_ImemValid_1 ? FETCH : DROP;
                endcase
            end else begin
                case (state)
                    IDLE: state <= FETCH;
                    FETCH: begin
                        if (accepted) begin
                            req_pc <= pc;
                            pc     <= pc + 32'd4;
                            state  <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (i_ImemValid_1) begin
                            state <= FETCH;
                        end
                    end
                    default: begin
                        if (i_ImemValid_1) begin
                            state <= FETCH;
                        end
                    end
                endcase
                if (fill) begin
                    o_InstValid_1 <= 1'b1;
                    o_Inst_32     <= i_ImemData_32;
                    o_InstPC_32   <= req_pc;
                end else if (o_InstValid_1 && !i_Stall_1) begin
                    o_InstValid_1 <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_control.sv
// tb/tb_pc_fetch_control.sv - directed self-checking bench for pc_fetch_control
module tb_pc_fetch_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jump;
    logic [31:0] target;
    logic        stall;
    logic        ready;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic        req;
    logic [31:0] addr;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        flush;

    int tests = 0;
    int fails = 0;
    logic auto_mem = 1'b0;

    pc_fetch_control #(.RESET_PC(32'h0000_0100)) dut (
        .i_Clk_1        (clk),
        .i_Rst_n_1      (rst_n),
        .i_Jump_1       (jump),
        .i_JumpTarget_32(target),
        .i_Stall_1      (stall),
        .i_ImemReady_1  (ready),
        .i_ImemValid_1  (imem_valid),
        .i_ImemData_32  (imem_data),
        .o_ImemReq_1    (req),
        .o_ImemAddr_32  (addr),
        .o_InstValid_1  (inst_valid),
        .o_Inst_32      (inst),
        .o_InstPC_32    (inst_pc),
        .o_Flush_1      (flush)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // One clock: optionally model a 1-cycle-latency memory answering the accepted request.
    task automatic step();
        logic        acc;
        logic [31:0] a;
        #1;
        acc = req & ready;
        a   = addr;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            imem_valid = acc;
            imem_data  = mem_word(a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; jump = 1'b0; target = 32'h0; stall = 1'b0; ready = 1'b1;
        imem_valid = 1'b0; imem_data = 32'h0;
        step(); step();
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", req); end
        tests++; if (addr !== 32'h100) begin fails++; $display("FAIL reset_addr got %h exp 100", addr); end
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
        tests++; if (inst !== 32'h13) begin fails++; $display("FAIL reset_inst got %h exp 13", inst); end
        tests++; if (inst_pc !== 32'h100) begin fails++; $display("FAIL reset_instpc got %h exp 100", inst_pc); end
        tests++; if (flush !== 1'b0) begin fails++; $display("FAIL reset_flush got %b exp 0", flush); end
    endtask

    task automatic test_stream();
        rst_n = 1'b1; auto_mem = 1'b1;
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL stream_idle_valid got %b exp 0", inst_valid); end
        step();
        tests++; if (req !== 1'b1 || addr !== 32'h100) begin fails++; $display("FAIL stream_req0 got %b/%h exp 1/100", req, addr); end
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL stream_valid1 got %b exp 0", inst_valid); end
        step();
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL stream_wait_req got %b exp 0", req); end
        step();
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== 32'hDEAD_0100) begin
            fails++; $display("FAIL stream_inst0 got %b/%h/%h exp 1/100/dead0100", inst_valid, inst_pc, inst); end
        tests++; if (req !== 1'b1 || addr !== 32'h104) begin fails++; $display("FAIL stream_req1 got %b/%h exp 1/104", req, addr); end
        step();
        tests++; if (inst_valid !== 1'b0 || req !== 1'b0) begin fails++; $display("FAIL stream_gap got %b/%b exp 0/0", inst_valid, req); end
        step();
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h104) begin fails++; $display("FAIL stream_inst1 got %b/%h exp 1/104", inst_valid, inst_pc); end
        tests++; if (req !== 1'b1 || addr !== 32'h108) begin fails++; $display("FAIL stream_req2 got %b/%h exp 1/108", req, addr); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++; if (req !== 1'b0 || addr !== 32'h108) begin fails++; $display("FAIL stall_req[%0d] got %b/%h exp 0/108", i, req, addr); end
            tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h104 || inst !== 32'hDEAD_0104) begin
                fails++; $display("FAIL stall_buf[%0d] got %b/%h/%h exp 1/104/dead0104", i, inst_valid, inst_pc, inst); end
            step();
        end
        stall = 1'b0;
        #1;
        tests++; if (req !== 1'b1 || addr !== 32'h108) begin fails++; $display("FAIL stall_resume got %b/%h exp 1/108", req, addr); end
        step(); step();
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h108) begin fails++; $display("FAIL stall_fill got %b/%h exp 1/108", inst_valid, inst_pc); end
    endtask

    task automatic test_jump_wait();
        auto_mem = 1'b0; imem_valid = 1'b0;
        step();
        jump = 1'b1; target = 32'h200;
        step();
        jump = 1'b0;
        tests++; if (flush !== 1'b1 || req !== 1'b0 || inst_valid !== 1'b0) begin
            fails++; $display("FAIL jw_drop got flush %b req %b valid %b exp 1/0/0", flush, req, inst_valid); end
        step();
        tests++; if (flush !== 1'b0 || req !== 1'b0) begin fails++; $display("FAIL jw_hold got flush %b req %b exp 0/0", flush, req); end
        imem_valid = 1'b1; imem_data = 32'h0BAD_0BAD;
        step();
        imem_valid = 1'b0;
        tests++; if (inst_valid !== 1'b0 || req !== 1'b1 || addr !== 32'h200) begin
            fails++; $display("FAIL jw_redirect got %b/%b/%h exp 0/1/200", inst_valid, req, addr); end
        auto_mem = 1'b1;
        step(); step();
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst !== 32'hDEAD_0200) begin
            fails++; $display("FAIL jw_newpath got %b/%h/%h exp 1/200/dead0200", inst_valid, inst_pc, inst); end
    endtask

    task automatic test_jump_accept();
        jump = 1'b1; target = 32'h303;
        step();
        jump = 1'b0;
        tests++; if (req !== 1'b0 || addr !== 32'h300 || inst_valid !== 1'b0 || flush !== 1'b1) begin
            fails++; $display("FAIL ja_drop got %b/%h/%b/%b exp 0/300/0/1", req, addr, inst_valid, flush); end
        step();
        tests++; if (req !== 1'b1 || addr !== 32'h300 || inst_valid !== 1'b0) begin
            fails++; $display("FAIL ja_fetch got %b/%h/%b exp 1/300/0", req, addr, inst_valid); end
        step(); step();
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h300) begin fails++; $display("FAIL ja_inst got %b/%h exp 1/300", inst_valid, inst_pc); end
    endtask

    task automatic test_jump_fill_stall();
        auto_mem = 1'b0; imem_valid = 1'b0;
        step();
        imem_valid = 1'b1; imem_data = 32'h0000_1234; stall = 1'b1; jump = 1'b1; target = 32'h400;
        step();
        imem_valid = 1'b0; jump = 1'b0; stall = 1'b0;
        tests++; if (inst_valid !== 1'b0 || req !== 1'b1 || addr !== 32'h400 || flush !== 1'b1) begin
            fails++; $display("FAIL jfs got %b/%b/%h/%b exp 0/1/400/1", inst_valid, req, addr, flush); end
    endtask

    task automatic test_back_to_back_jump();
        ready = 1'b0;
        jump = 1'b1; target = 32'h500;
        step();
        target = 32'h600;
        step();
        jump = 1'b0;
        tests++; if (addr !== 32'h600 || req !== 1'b1 || flush !== 1'b1) begin
            fails++; $display("FAIL b2b_jump got %h/%b/%b exp 600/1/1", addr, req, flush); end
        step();
        tests++; if (flush !== 1'b0 || addr !== 32'h600) begin fails++; $display("FAIL b2b_hold got %b/%h exp 0/600", flush, addr); end
    endtask

    task automatic test_wrap();
        jump = 1'b1; target = 32'hFFFF_FFFF;
        step();
        jump = 1'b0;
        tests++; if (addr !== 32'hFFFF_FFFC || req !== 1'b1) begin fails++; $display("FAIL wrap_target got %h/%b exp fffffffc/1", addr, req); end
        ready = 1'b1;
        step();
        tests++; if (addr !== 32'h0) begin fails++; $display("FAIL wrap_pc got %h exp 0", addr); end
        imem_valid = 1'b1; imem_data = 32'h0000_00EF;
        step();
        imem_valid = 1'b0;
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst !== 32'hEF) begin
            fails++; $display("FAIL wrap_inst got %b/%h/%h exp 1/fffffffc/ef", inst_valid, inst_pc, inst); end
    endtask

    task automatic test_reset_wait();
        step();
        step();
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL rw_inwait got req %b exp 0", req); end
        rst_n = 1'b0;
        step();
        tests++; if (req !== 1'b0 || addr !== 32'h100 || inst_valid !== 1'b0 || inst !== 32'h13 || inst_pc !== 32'h100 || flush !== 1'b0) begin
            fails++; $display("FAIL rw_reset got %b/%h/%b/%h/%h/%b exp 0/100/0/13/100/0", req, addr, inst_valid, inst, inst_pc, flush); end
        rst_n = 1'b1; imem_valid = 1'b1; imem_data = 32'h0BAD_F00D;
        step();
        imem_valid = 1'b0;
        tests++; if (inst_valid !== 1'b0 || inst !== 32'h13 || req !== 1'b1 || addr !== 32'h100) begin
            fails++; $display("FAIL rw_stale got %b/%h/%b/%h exp 0/13/1/100", inst_valid, inst, req, addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_jump_wait();
        test_jump_accept();
        test_jump_fill_stall();
        test_back_to_back_jump();
        test_wrap();
        test_reset_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
